// File: rtl/mem_pkg.sv
// Shared state encoding, RV64 load/store funct3 codes and the alignment rule
// for the MEM-stage access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] offset);
    case (funct3[1:0])
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~offset[0];
      2'b10:   is_aligned = (offset[1:0] == 2'b00);
      default: is_aligned = (offset == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory bus between the MEM stage (master) and the
// data memory (slave).
interface mem_access_unit_if #(
  parameter int XLEN = 64
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wstrb;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/data shift, load extraction
// with sign/zero extension, and illegal-access detection.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      offset_i,
  input  logic [2:0]      funct3_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [7:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] rdata_sh;

  assign wdata_o  = wdata_i << {offset_i, 3'b000};
  assign rdata_sh = rdata_i >> {offset_i, 3'b000};

  assign illegal_o = (funct3_i == F3_BAD)
                   | (is_store_i & funct3_i[2])
                   | ~is_aligned(funct3_i, offset_i);

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   wstrb_o = 8'h01 << offset_i;
      2'b01:   wstrb_o = 8'h03 << offset_i;
      2'b10:   wstrb_o = 8'h0F << offset_i;
      default: wstrb_o = 8'hFF;
    endcase
  end

  // NOTE: every always_comb output gets a value on every path (default arm here)
  // so no latch is inferred.
  always_comb begin
    case (funct3_i)
      F3_B:    load_o = {{(XLEN-8){rdata_sh[7]}},   rdata_sh[7:0]};
      F3_H:    load_o = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
      F3_W:    load_o = {{(XLEN-32){rdata_sh[31]}}, rdata_sh[31:0]};
      F3_D:    load_o = rdata_sh;
      F3_BU:   load_o = {{(XLEN-8){1'b0}},  rdata_sh[7:0]};
      F3_HU:   load_o = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
      F3_WU:   load_o = {{(XLEN-32){1'b0}}, rdata_sh[31:0]};
      default: load_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage responder: turns one EX/MEM load/store into one req/ack bus
// transaction, stalling the pipeline until it completes or faults.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic [XLEN-1:0] Addr_in,
  input  logic [XLEN-1:0] WData_in,
  input  logic [2:0]      Funct3_in,
  output logic            Stall,
  output logic [XLEN-1:0] LoadData,
  output logic            LoadValid,
  output logic            Done,
  output logic            AccessErr,
  output logic            BusErr,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      wstrb_q, wstrb_d;
  logic [2:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic            load_valid_q, load_valid_d;
  logic            done_q, done_d;
  logic            access_err_q, access_err_d;
  logic            bus_err_q, bus_err_d;

  logic            access;
  logic            illegal;
  logic            timeout_hit;
  logic [2:0]      lane_off;
  logic [2:0]      lane_f3;
  logic [7:0]      lane_wstrb;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_load;
  logic            lane_illegal;

  // While idle the lanes decode the incoming instruction; afterwards they use
  // the latched offset/funct3 to extract the returning read data.
  assign lane_off = (state_q == IDLE) ? Addr_in[2:0] : off_q;
  assign lane_f3  = (state_q == IDLE) ? Funct3_in    : f3_q;

  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .offset_i   (lane_off),
    .funct3_i   (lane_f3),
    .is_store_i (MemWrite_in),
    .wdata_i    (WData_in),
    .rdata_i    (bus.mem_rdata),
    .wstrb_o    (lane_wstrb),
    .wdata_o    (lane_wdata),
    .load_o     (lane_load),
    .illegal_o  (lane_illegal)
  );

  assign access      = MemRead_in | MemWrite_in;
  assign illegal     = lane_illegal | (MemRead_in & MemWrite_in);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      done_q       <= 1'b0;
      access_err_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      done_q       <= done_d;
      access_err_q <= access_err_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    off_d        = off_q;
    f3_d         = f3_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    done_d       = 1'b0;
    access_err_d = 1'b0;
    bus_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            state_d      = DONE;
            done_d       = 1'b1;
            access_err_d = 1'b1;
            load_data_d  = '0;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = MemWrite_in;
            addr_d  = {Addr_in[XLEN-1:3], 3'b000};
            wdata_d = lane_wdata;
            wstrb_d = MemWrite_in ? lane_wstrb : 8'h00;
            off_d   = Addr_in[2:0];
            f3_d    = Funct3_in;
          end
        end
      end
      REQ: begin
        // An ack in the final allowed cycle still completes normally.
        if (bus.mem_ack) begin
          state_d      = DONE;
          req_d        = 1'b0;
          done_d       = 1'b1;
          if (!we_q) begin
            load_data_d  = lane_load;
            load_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d     = DONE;
          req_d       = 1'b0;
          done_d      = 1'b1;
          bus_err_d   = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE:    Stall = access;
        REQ:     Stall = 1'b1;
        default: Stall = 1'b0;
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  assign LoadData  = load_data_q;
  assign LoadValid = load_valid_q;
  assign Done      = done_q;
  assign AccessErr = access_err_q;
  assign BusErr    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: each access pushes its
// expected completion into a scoreboard that is popped when Done pulses.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TO = 5;

  typedef struct packed {
    logic [63:0] load_data;
    logic        load_valid;
    logic        access_err;
    logic        bus_err;
    logic        chk_data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [63:0] Addr_in;
  logic [63:0] WData_in;
  logic [2:0]  Funct3_in;
  logic        Stall;
  logic [63:0] LoadData;
  logic        LoadValid;
  logic        Done;
  logic        AccessErr;
  logic        BusErr;

  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  mem_access_unit_if #(.XLEN(64)) bus ();

  mem_access_unit #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead_in  (MemRead_in),
    .MemWrite_in (MemWrite_in),
    .Addr_in     (Addr_in),
    .WData_in    (WData_in),
    .Funct3_in   (Funct3_in),
    .Stall       (Stall),
    .LoadData    (LoadData),
    .LoadValid   (LoadValid),
    .Done        (Done),
    .AccessErr   (AccessErr),
    .BusErr      (BusErr),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk_exp(input logic [63:0] ld, input logic lv, input logic ae,
                                  input logic be, input logic cd);
    exp_t e;
    e.load_data  = ld;
    e.load_valid = lv;
    e.access_err = ae;
    e.bus_err    = be;
    e.chk_data   = cd;
    return e;
  endfunction

  // ack_cycle: REQ cycle (1-based) in which the responder acks; 0 = never.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [63:0] addr, input logic [63:0] wd, input logic [2:0] f3,
                           input logic [63:0] rdata, input int ack_cycle,
                           input int exp_stall, input int exp_req,
                           input logic [7:0] exp_wstrb, input logic [63:0] exp_wdata,
                           input exp_t e);
    int          stalls;
    int          reqs;
    bit          got_done;
    bit          stable;
    logic [63:0] addr0;
    logic [63:0] wdata0;
    logic [7:0]  wstrb0;
    logic        we0;
    exp_t        got;
    stalls = 0; reqs = 0; got_done = 0; stable = 1;
    addr0 = '0; wdata0 = '0; wstrb0 = '0; we0 = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    MemRead_in = rd; MemWrite_in = wr; Addr_in = addr; WData_in = wd; Funct3_in = f3;
    for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
      #1;
      if (Stall) stalls++;
      if (bus.mem_req) begin
        reqs++;
        if (reqs == 1) begin
          addr0 = bus.mem_addr; wdata0 = bus.mem_wdata; wstrb0 = bus.mem_wstrb; we0 = bus.mem_we;
        end else if (bus.mem_addr !== addr0 || bus.mem_wdata !== wdata0 ||
                     bus.mem_wstrb !== wstrb0 || bus.mem_we !== we0) begin
          stable = 0;
        end
        bus.mem_ack   = (reqs == ack_cycle);
        bus.mem_rdata = rdata;
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (Done) begin
        got_done = 1;
        MemRead_in = 1'b0; MemWrite_in = 1'b0;
        got = exp_q.pop_front();
        check({tag, "/LoadValid"}, LoadValid, got.load_valid);
        check({tag, "/AccessErr"}, AccessErr, got.access_err);
        check({tag, "/BusErr"},    BusErr,    got.bus_err);
        check({tag, "/Stall@done"}, Stall, 1'b0);
        if (got.chk_data) check({tag, "/LoadData"}, LoadData, got.load_data);
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "/done_seen"}, got_done, 1'b1);
    check({tag, "/stall_cycles"}, stalls, exp_stall);
    check({tag, "/req_cycles"}, reqs, exp_req);
    check({tag, "/bus_stable"}, stable, 1'b1);
    if (exp_req > 0) begin
      check({tag, "/mem_addr"}, addr0, {addr[63:3], 3'b000});
      check({tag, "/mem_we"}, we0, wr);
      if (wr) begin
        check({tag, "/mem_wstrb"}, wstrb0, exp_wstrb);
        check({tag, "/mem_wdata"}, wdata0, exp_wdata);
      end
    end
    @(negedge clk);
    #1;
    check({tag, "/done_pulse"}, Done, 1'b0);
    check({tag, "/lv_pulse"}, LoadValid, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    MemRead_in = 1'b1; MemWrite_in = 1'b0;
    Addr_in = '0; WData_in = '0; Funct3_in = F3_D;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Reset state, with a pending load held on the inputs.
    @(negedge clk); #1;
    check("rst/Stall", Stall, 1'b0);
    check("rst/mem_req", bus.mem_req, 1'b0);
    check("rst/mem_addr", bus.mem_addr, 64'h0);
    check("rst/mem_wstrb", bus.mem_wstrb, 8'h00);
    check("rst/LoadData", LoadData, 64'h0);
    check("rst/flags", {LoadValid, Done, AccessErr, BusErr}, 4'b0000);
    MemRead_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    do_access("ld_1000", 1, 0, 64'h1000, 64'h0, F3_D, 64'h1122334455667788, 1, 2, 1, 8'h00, 64'h0,
              mk_exp(64'h1122334455667788, 1, 0, 0, 1));
    do_access("lb_1003", 1, 0, 64'h1003, 64'h0, F3_B, 64'h0000000080000000, 1, 2, 1, 8'h00, 64'h0,
              mk_exp(64'hFFFFFFFFFFFFFF80, 1, 0, 0, 1));
    do_access("lbu_1003", 1, 0, 64'h1003, 64'h0, F3_BU, 64'h0000000080000000, 1, 2, 1, 8'h00, 64'h0,
              mk_exp(64'h0000000000000080, 1, 0, 0, 1));
    do_access("sh_2006", 0, 1, 64'h2006, 64'hABCD, F3_H, 64'h0, 4, 5, 4, 8'hC0, 64'hABCD000000000000,
              mk_exp(64'h0, 0, 0, 0, 0));
    do_access("sw_600c", 0, 1, 64'h600C, 64'hDEADBEEF, F3_W, 64'h0, 2, 3, 2, 8'hF0, 64'hDEADBEEF00000000,
              mk_exp(64'h0, 0, 0, 0, 0));
    do_access("sb_7005", 0, 1, 64'h7005, 64'h5A, F3_B, 64'h0, 1, 2, 1, 8'h20, 64'h00005A0000000000,
              mk_exp(64'h0, 0, 0, 0, 0));
    do_access("sd_8000", 0, 1, 64'h8000, 64'h0123456789ABCDEF, F3_D, 64'h0, 1, 2, 1, 8'hFF,
              64'h0123456789ABCDEF, mk_exp(64'h0, 0, 0, 0, 0));
    do_access("lhu_5006", 1, 0, 64'h5006, 64'h0, F3_HU, 64'hBEEF000000000000, 1, 2, 1, 8'h00, 64'h0,
              mk_exp(64'h000000000000BEEF, 1, 0, 0, 1));
    do_access("lw_3002_misal", 1, 0, 64'h3002, 64'h0, F3_W, 64'h0, 1, 1, 0, 8'h00, 64'h0,
              mk_exp(64'h0, 0, 1, 0, 0));
    do_access("rd_and_wr", 1, 1, 64'h3000, 64'h0, F3_D, 64'h0, 1, 1, 0, 8'h00, 64'h0,
              mk_exp(64'h0, 0, 1, 0, 0));
    do_access("store_f3_100", 0, 1, 64'h3000, 64'h0, F3_BU, 64'h0, 1, 1, 0, 8'h00, 64'h0,
              mk_exp(64'h0, 0, 1, 0, 0));
    do_access("ld_timeout", 1, 0, 64'h9000, 64'h0, F3_D, 64'hFFFFFFFFFFFFFFFF, 0, TO + 1, TO, 8'h00, 64'h0,
              mk_exp(64'h0, 0, 0, 1, 1));
    do_access("lw_ack_last", 1, 0, 64'h4004, 64'h0, F3_W, 64'h8765432100000000, TO, TO + 1, TO, 8'h00,
              64'h0, mk_exp(64'hFFFFFFFF87654321, 1, 0, 0, 1));

    // Reset in the middle of a request, then a stray ack while idle.
    @(negedge clk);
    MemRead_in = 1'b1; Addr_in = 64'hA000; Funct3_in = F3_D;
    @(negedge clk); #1;
    check("rstreq/req_before", bus.mem_req, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("rstreq/req_dropped", bus.mem_req, 1'b0);
    check("rstreq/Stall", Stall, 1'b0);
    check("rstreq/state", 64'(dut.state_q), 64'(IDLE));
    MemRead_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'h5555555555555555;
    @(negedge clk); #1;
    check("late_ack/Done", Done, 1'b0);
    check("late_ack/LoadValid", LoadValid, 1'b0);
    check("late_ack/mem_req", bus.mem_req, 1'b0);
    check("late_ack/state", 64'(dut.state_q), 64'(IDLE));
    bus.mem_ack = 1'b0;

    do_access("ld_after_rst", 1, 0, 64'h9008, 64'h0, F3_D, 64'hCAFEF00DDEADBEEF, 1, 2, 1, 8'h00, 64'h0,
              mk_exp(64'hCAFEF00DDEADBEEF, 1, 0, 0, 1));

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage responder sitting on the output side of the EX/MEM pipeline register.
- Consumes the registered MemRead/MemWrite, ALU address and store data, and runs one transaction per access on a req/ack data-memory bus with variable latency.
- Stalls the pipeline until the access completes, then presents the sign/zero-extended load data to the MEM/WB register.
- Detects misaligned or illegal accesses and bus timeouts.

Parameters:
- XLEN, 64, data and address width.
- TIMEOUT_CYCLES, 255, maximum REQ cycles without mem_ack before a bus error is raised; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead_in  in  1  load request from EX/MEM.
- MemWrite_in  in  1  store request from EX/MEM.
- Addr_in  in  XLEN  byte address (ALU result).
- WData_in  in  XLEN  store data, right-aligned.
- Funct3_in  in  3  access size and signedness (RV64 load/store funct3).
- Stall  out  1  holds the EX/MEM and earlier stages.
- LoadData  out  XLEN  extended load result, registered.
- LoadValid  out  1  1-cycle pulse: LoadData is valid.
- Done  out  1  1-cycle pulse on completion of any access, including error completions.
- AccessErr  out  1  1-cycle pulse with Done: misaligned, illegal funct3, or MemRead_in and MemWrite_in both high.
- BusErr  out  1  1-cycle pulse with Done: timeout expired.
- mem_req  out  1  bus request.
- mem_we  out  1  1 for write.
- mem_addr  out  XLEN  doubleword-aligned address {Addr[XLEN-1:3], 3'b0}.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  8  byte enables.
- mem_ack  in  1  completion; valid only while mem_req=1.
- mem_rdata  in  XLEN  read doubleword; valid with mem_ack.

Behaviour:
- Reset (asynchronous): state=IDLE, timeout counter=0, and every registered output=0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, LoadData, LoadValid, Done, AccessErr, BusErr). Stall is forced to 0 while reset=1.
- Reset asserted mid-REQ drops mem_req immediately. An ack arriving after reset while in IDLE is ignored.
- State IDLE:
  - access = MemRead_in|MemWrite_in.
  - Stall = access, combinationally, in the same cycle.
  - Legal access → REQ. On that edge, latch mem_we, mem_addr, mem_wdata, mem_wstrb, offset=Addr_in[2:0] and funct3; assert mem_req.
  - Illegal access → DONE with AccessErr; no bus transaction.
- State REQ:
  - Stall=1. mem_req and all bus outputs are held stable until an ack.
  - mem_ack=1 at an edge: drop mem_req, capture the extracted load data, → DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: drop mem_req, LoadData=0, → DONE with BusErr.
- State DONE:
  - Stall=0; Done=1; LoadValid=1 only for an error-free read.
  - DONE → IDLE unconditionally. EX/MEM advances on this edge, so the same instruction is never re-issued.
- Latency: with an ack in the first REQ cycle, an access occupies 3 cycles (IDLE, REQ, DONE), i.e. 2 stall cycles. Each extra ack wait adds 1 cycle.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0. funct3=111, or a store funct3 ≥100, is illegal.
- Stores:
  - mem_wstrb: SB=8'h01<<off, SH=8'h03<<off, SW=8'h0F<<off, SD=8'hFF.
  - mem_wdata = WData_in << (8*off).
- Loads:
  - raw = mem_rdata >> (8*off), truncated to the access size.
  - funct3 000/001/010 sign-extend; 100/101/110 zero-extend; 011 passes through.
- Bus rules:
  - No new request is issued in the same cycle as an ack.
  - Back-to-back accesses are separated by at least the DONE cycle.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, REQ, DONE};
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - helper function for the alignment-legal check.
- Sub-module mem_lane_align (purely combinational):
  - inputs: offset, funct3, WData, rdata;
  - outputs: wstrb, shifted wdata, extended load data, illegal flag.

Test Plan:
- LD from 0x1000, ack on the first REQ cycle, rdata=0x1122334455667788 → Stall high for 2 cycles; mem_addr=0x1000; LoadData=0x1122334455667788 with LoadValid and Done in the 3rd cycle.
- LB at 0x1003, rdata=0x00000000_80000000 → byte 0x80, LoadData=0xFFFFFFFFFFFFFF80. Same with LBU → 0x80.
- SH at 0x2006, WData=0xABCD → mem_wstrb=8'hC0, mem_wdata=0xABCD000000000000, mem_we=1. Ack delayed 4 cycles → Stall for 5 cycles; bus outputs stable throughout.
- LW at 0x3002 → AccessErr+Done one cycle later; mem_req never asserted; LoadValid=0. MemRead_in=MemWrite_in=1 → same response.
- TIMEOUT_CYCLES=3, no ack → mem_req high for 3 cycles, then BusErr+Done, LoadData=0, Stall released.
- reset pulsed during REQ → mem_req=0 immediately and state=IDLE. A late ack is ignored; a following LD completes normally.
